// File: rtl/nios_debug_scan_pkg.sv
// Shared definitions for the Nios II virtual-JTAG debug scan master.
//   - scan_state_e : scan FSM state encoding
//   - DEF_DR_WIDTH / DEF_IR_WIDTH : default data/IR register widths
//   - IR_* : virtual IR codes understood by the CPU debug slave
package nios_debug_scan_pkg;

  localparam int DEF_DR_WIDTH = 38;
  localparam int DEF_IR_WIDTH = 2;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACE     = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RTI  = 3'd5,
    ST_RESP = 3'd6
  } scan_state_e;

endpackage

// File: rtl/nios_setup_cpu_debug_tck_gen.sv
// Divided JTAG clock generator for the debug scan master.
// tck is low for CLK_DIV clk cycles, then high for CLK_DIV cycles, while
// run_i is high; it is forced low and the divider reloaded otherwise, so
// every run starts at the beginning of a low phase.
// Ports:
//   clk, reset_n   : system clock, async active-low reset
//   run_i          : generate tck periods
//   tck_o          : registered divided clock
//   rise_next_o    : the coming clk edge drives tck high (tdo sample point)
//   period_end_o   : the coming clk edge drives tck low (period boundary)
module nios_setup_cpu_debug_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run_i,
  output logic tck_o,
  output logic rise_next_o,
  output logic period_end_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          tc;

  assign tc = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!run_i) begin
      cnt_d = HALF_LOAD;
      tck_d = 1'b0;
    end else if (tc) begin
      cnt_d = HALF_LOAD;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= HALF_LOAD;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o        = tck_q;
  assign rise_next_o  = run_i && tc && !tck_q;
  assign period_end_o = run_i && tc && tck_q;

endmodule

// File: rtl/nios_setup_cpu_debug_scan_master.sv
// Host-side initiator of the Nios II virtual-JTAG debug register protocol.
// Each accepted command performs one UIR/CDR/SDR/UDR/RTI sequence, shifting
// cmd_data into the slave LSB first and returning the word shifted out.
//
// state | meaning
// IDLE  | ready for a command; one extra cycle after accept before UIR
// UIR   | 1 tck period, vs_uir high, slave latches ir_in
// CDR   | 1 tck period, vs_cdr high, slave captures its DR
// SDR   | DR_WIDTH tck periods, vs_sdr high, tdi out / tdo in
// UDR   | 1 tck period, vs_udr high
// RTI   | RTI_TCKS tck periods, jtag_state_rti high
// RESP  | rsp_valid high until rsp_ready
//
// Optional feature (macro NIOS_DEBUG_SCAN_IR_CACHE_EN): remembers the last
// scanned IR and skips UIR when the next command carries the same IR.
//
// Ports:
//   clk, reset_n                 : system clock, async active-low reset
//   cmd_valid/cmd_ready          : command handshake
//   cmd_ir, cmd_data             : IR and DR word for the scan
//   rsp_valid/rsp_ready          : response handshake
//   rsp_data                     : DR word captured from tdo
//   busy                         : scan in progress
//   tck, tdi, tdo, ir_in         : virtual JTAG signals to/from the slave
//   vs_uir/vs_cdr/vs_sdr/vs_udr  : virtual state strobes
//   jtag_state_rti               : run-test-idle indicator
module nios_setup_cpu_debug_scan_master
  import nios_debug_scan_pkg::*;
#(
  parameter int DR_WIDTH = DEF_DR_WIDTH,
  parameter int IR_WIDTH = DEF_IR_WIDTH,
  parameter int CLK_DIV  = 2,
  parameter int RTI_TCKS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                busy,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int PCW = $clog2(DR_WIDTH + RTI_TCKS + 1);

  scan_state_e         state_q, state_d;
  logic                start_q, start_d;
  logic [PCW-1:0]      per_q, per_d;
  logic [DR_WIDTH-1:0] tx_q, tx_d;
  logic [DR_WIDTH-1:0] rx_q, rx_d;
  logic                tdi_q, tdi_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;

  logic run;
  logic rise_next;
  logic period_end;
  logic accept;
  logic skip_uir;

  assign accept = cmd_valid && cmd_ready;
  assign run    = state_q inside {ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI};

  nios_setup_cpu_debug_tck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tck_gen (
    .clk          (clk),
    .reset_n      (reset_n),
    .run_i        (run),
    .tck_o        (tck),
    .rise_next_o  (rise_next),
    .period_end_o (period_end)
  );

`ifdef NIOS_DEBUG_SCAN_IR_CACHE_EN
  logic [IR_WIDTH-1:0] cache_ir_q;
  logic                cache_vld_q;
  logic                skip_q;

  // The hit decision is taken at accept time, against the IR of the
  // previous scan, and then the cache is refreshed with the new IR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_ir_q  <= '0;
      cache_vld_q <= 1'b0;
      skip_q      <= 1'b0;
    end else if (accept) begin
      skip_q      <= cache_vld_q && (cmd_ir == cache_ir_q);
      cache_ir_q  <= cmd_ir;
      cache_vld_q <= 1'b1;
    end
  end

  assign skip_uir = skip_q;
`else
  assign skip_uir = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    per_d   = per_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    tdi_d   = tdi_q;
    ir_d    = ir_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          start_d = 1'b0;
          per_d   = '0;
          state_d = skip_uir ? ST_CDR : ST_UIR;
        end else if (accept) begin
          start_d = 1'b1;
          tx_d    = cmd_data;
          ir_d    = cmd_ir;
        end
      end

      ST_UIR: begin
        if (period_end) begin
          state_d = ST_CDR;
          per_d   = '0;
        end
      end

      // tdi changes only on the edge that drops tck, so it is stable
      // across the whole high phase the slave samples on.
      ST_CDR: begin
        if (period_end) begin
          state_d = ST_SDR;
          per_d   = PCW'(DR_WIDTH - 1);
          tdi_d   = tx_q[0];
          tx_d    = tx_q >> 1;
        end
      end

      // tdo is taken on the edge that raises tck, before the slave shifts.
      ST_SDR: begin
        if (rise_next) begin
          rx_d = {tdo, rx_q[DR_WIDTH-1:1]};
        end
        if (period_end) begin
          if (per_q == '0) begin
            state_d = ST_UDR;
            tdi_d   = 1'b0;
          end else begin
            per_d = per_q - PCW'(1);
            tdi_d = tx_q[0];
            tx_d  = tx_q >> 1;
          end
        end
      end

      ST_UDR: begin
        if (period_end) begin
          state_d = ST_RTI;
          per_d   = PCW'(RTI_TCKS - 1);
        end
      end

      ST_RTI: begin
        if (period_end) begin
          if (per_q == '0) begin
            state_d = ST_RESP;
          end else begin
            per_d = per_q - PCW'(1);
          end
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      per_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      tdi_q   <= 1'b0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      per_q   <= per_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      tdi_q   <= tdi_d;
      ir_q    <= ir_d;
    end
  end

  assign cmd_ready      = (state_q == ST_IDLE) && !start_q;
  assign busy           = start_q || run;
  assign rsp_valid      = (state_q == ST_RESP);
  assign rsp_data       = rx_q;
  assign tdi            = tdi_q;
  assign ir_in          = ir_q;
  assign vs_uir         = (state_q == ST_UIR);
  assign vs_cdr         = (state_q == ST_CDR);
  assign vs_sdr         = (state_q == ST_SDR);
  assign vs_udr         = (state_q == ST_UDR);
  assign jtag_state_rti = (state_q == ST_RTI);

endmodule

// File: doc/nios_setup_cpu_debug_scan_master.md
Name: nios_setup_cpu_debug_scan_master

Overview:
- Host-side initiator of the Nios II virtual-JTAG debug register protocol.
- Generates the tck/tdi/ir_in/virtual-state strobes that the CPU debug slave's tck domain consumes, and captures its tdo.
- Performs one complete IR+DR scan per command: shifts a DR_WIDTH-bit word in and returns the word shifted out.
- Used for on-chip debug bring-up and as the bench driver for the CPU debug slave.

Parameters:
- DR_WIDTH, 38, shift-register length (matches debug slave sr/jdo).
- IR_WIDTH, 2, virtual IR width.
- CLK_DIV, 2, clk cycles per tck half-period; must be >= 1.
- RTI_TCKS, 2, tck periods spent in run-test-idle after update; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  scan request.
- cmd_ready  out  1  master idle; accepts a request.
- cmd_ir  in  IR_WIDTH  IR value for this scan.
- cmd_data  in  DR_WIDTH  word to shift in, LSB first.
- rsp_valid  out  1  scan complete; rsp_data valid.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DR_WIDTH  word captured from tdo, LSB first.
- busy  out  1  scan in progress.
- tck  out  1  registered divided JTAG clock.
- tdi  out  1  serial data to slave.
- tdo  in  1  serial data from slave (slave sr[0]).
- ir_in  out  IR_WIDTH  virtual IR to slave.
- vs_uir, vs_cdr, vs_sdr, vs_udr  out  1 each  virtual state strobes.
- jtag_state_rti  out  1  run-test-idle indicator.

Behaviour:
- Reset values: tck=0, tdi=0, ir_in=0, all vs_* =0, jtag_state_rti=0, cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0.
- Reset is asynchronous. Asserting it mid-scan aborts the scan immediately and discards it; no response is produced.
- A tck period is 2*CLK_DIV clk cycles: CLK_DIV cycles low, then CLK_DIV cycles high.
- FSM states: IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> RESP -> IDLE.
  - Each non-IDLE/RESP state occupies whole tck periods.
  - Transitions occur at a tck falling edge, i.e. when the period ends.
- IDLE: cmd_ready=1, tck held 0.
  - On cmd_valid&&cmd_ready, latch cmd_ir and cmd_data, then enter UIR on the next cycle with busy=1.
- UIR: 1 period; vs_uir=1; ir_in=latched IR, held stable through RESP.
- CDR: 1 period; vs_cdr=1.
- SDR: DR_WIDTH periods; vs_sdr=1.
  - tdi=bit i of latched data during period i, changing only while tck is low.
  - tdo is sampled into rsp_data bit i in the clk cycle that sets tck high, i.e. before the slave shifts.
- UDR: 1 period; vs_udr=1.
- RTI: RTI_TCKS periods; jtag_state_rti=1.
- Exactly one vs_* strobe is high in each of UIR/CDR/SDR/UDR; all are low elsewhere.
- RESP: tck=0, rsp_valid=1, rsp_data held stable until rsp_ready.
  - The handshake returns the FSM to IDLE on the next cycle.
  - cmd_ready stays 0 throughout busy and RESP; a cmd_valid arriving then is not accepted and must be held by the source.
- Latency: N = 1 + 1 + DR_WIDTH + 1 + RTI_TCKS periods. rsp_valid first rises N*2*CLK_DIV + 1 cycles after the accept edge.
  - Defaults: N=43, giving 173 cycles.
- rsp_ready high before rsp_valid has no effect.
- ir_in keeps the last IR after IDLE is re-entered; it returns to 0 only on reset.

Optional Feature:
- Macro: NIOS_DEBUG_SCAN_IR_CACHE_EN.
- Defined:
  - A register holds the last scanned IR plus a valid flag; the flag is cleared by reset.
  - If the flag is set and cmd_ir equals the stored IR, the UIR state is skipped (IDLE -> CDR) and latency becomes (N-1) periods.
- Undefined: UIR is always performed; no cache register exists.

Decomposition:
- Shared package nios_debug_scan_pkg holds:
  - the FSM state enum;
  - default DR_WIDTH/IR_WIDTH constants;
  - named IR codes: 2'b00 ocimem, 2'b01 trace, 2'b10 break, 2'b11 tracectrl.
- One sub-module, nios_setup_cpu_debug_tck_gen.
  - Contains the CLK_DIV counter and tck register.
  - Outputs per-cycle strobes: rise_next (sample point) and period_end (state advance point).

Test Plan:
- Basic scan. Setup: behavioural slave (tdo=sr[0]; sr loaded 38'h15_DEADBEEF on vs_cdr; shifts {tdi,sr[37:1]} on tck rise); cmd_ir=2'b01, cmd_data=38'h0A_12345678. Expected: slave sees ir_in=01 during vs_uir; slave sr=38'h0A_12345678 at vs_udr; rsp_data=38'h15_DEADBEEF; rsp_valid rises exactly 173 cycles after accept.
- Back-pressure. Setup: rsp_ready low 10 cycles after rsp_valid; cmd_valid held high with a new command. Expected: rsp_data stable; cmd_ready=0 until the cycle after the handshake; second scan accepted then.
- CLK_DIV=1, RTI_TCKS=1. Expected: tck toggles every cycle; rsp_valid at (1+1+38+1+1)*2+1 = 85 cycles.
- Reset mid-scan. Setup: reset_n low at SDR bit 20. Expected: all outputs at reset values in the same cycle; no rsp_valid; next command performs a full scan.
- With NIOS_DEBUG_SCAN_IR_CACHE_EN: two scans with ir=2'b10, then one with 2'b11. Expected: vs_uir is absent in scan 2 and present in scans 1 and 3; scan 2 latency is 169 cycles.
